// File: rtl/fetch_redirect_unit.sv
// Front-end PC generator: one outstanding fetch over valid/ready, one-entry skid
// register toward decode, and redirect handling that flushes the skid and in-flight response.
`timescale 1ns/1ps
module fetch_redirect_unit #(
  parameter int unsigned           ADDR_W   = 32,
  parameter int unsigned           INSN_W   = 32,
  parameter logic [ADDR_W-1:0]     RESET_PC = 32'h8000_0000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_needRedirect,
  input  logic [3:0]        io_Redirect_ID,
  input  logic [ADDR_W-1:0] io_Redirect_Target,
  input  logic              io_Exec_Redirect,
  input  logic [ADDR_W-1:0] io_Exec_Target,
  output logic              io_Fetch_Req_Valid,
  output logic [ADDR_W-1:0] io_Fetch_Req_Addr,
  input  logic              io_Fetch_Req_Ready,
  input  logic              io_Fetch_Resp_Valid,
  input  logic [INSN_W-1:0] io_Fetch_Resp_Data,
  output logic              io_Insn_Valid,
  output logic [INSN_W-1:0] io_Insn,
  output logic [ADDR_W-1:0] io_Insn_PC,
  input  logic              io_Insn_Ready,
  output logic              io_Flush,
  output logic [3:0]        io_Redirect_Src
);

  localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);
  localparam logic [3:0]        SRC_EXEC   = 4'hF;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DRAIN
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d;
  logic [ADDR_W-1:0] insn_pc_q, insn_pc_d;
  logic [INSN_W-1:0] insn_q, insn_d;
  logic              insn_valid_q, insn_valid_d;
  logic              flush_q, flush_d;
  logic [3:0]        src_q, src_d;

  logic              exec_redir;
  logic              dec_redir;
  logic              redir;
  logic [ADDR_W-1:0] redir_target;
  logic              req_valid;
  logic              req_fire;

  assign exec_redir   = io_Exec_Redirect;
  assign dec_redir    = io_needRedirect && (io_Redirect_ID != 4'd0);
  assign redir        = exec_redir || dec_redir;
  assign redir_target = exec_redir ? io_Exec_Target : io_Redirect_Target;

  // Qualified by reset so the request is visibly low for as long as reset is held.
  assign req_valid = reset && (state_q == S_IDLE) && (!insn_valid_q || io_Insn_Ready);
  assign req_fire  = req_valid && io_Fetch_Req_Ready;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_pc_d     = req_pc_q;
    insn_d       = insn_q;
    insn_pc_d    = insn_pc_q;
    insn_valid_d = insn_valid_q;
    flush_d      = redir;
    src_d        = '0;

    if (insn_valid_q && io_Insn_Ready) begin
      insn_valid_d = 1'b0;
    end

    unique case (state_q)
      S_IDLE: begin
        if (req_fire) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + PC_STEP;
          state_d  = redir ? S_DRAIN : S_WAIT;
        end
      end
      S_WAIT: begin
        if (io_Fetch_Resp_Valid) begin
          state_d = S_IDLE;
          if (!redir) begin
            insn_d       = io_Fetch_Resp_Data;
            insn_pc_d    = req_pc_q;
            insn_valid_d = 1'b1;
          end
        end else if (redir) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (io_Fetch_Resp_Valid) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Redirect wins over the sequential PC step and any skid load in the same cycle.
    if (redir) begin
      pc_d         = redir_target & ALIGN_MASK;
      insn_valid_d = 1'b0;
      src_d        = exec_redir ? SRC_EXEC : io_Redirect_ID;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      req_pc_q     <= '0;
      insn_q       <= '0;
      insn_pc_q    <= '0;
      insn_valid_q <= 1'b0;
      flush_q      <= 1'b0;
      src_q        <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_pc_q     <= req_pc_d;
      insn_q       <= insn_d;
      insn_pc_q    <= insn_pc_d;
      insn_valid_q <= insn_valid_d;
      flush_q      <= flush_d;
      src_q        <= src_d;
    end
  end

  assign io_Fetch_Req_Valid = req_valid;
  assign io_Fetch_Req_Addr  = pc_q;
  assign io_Insn_Valid      = insn_valid_q;
  assign io_Insn            = insn_q;
  assign io_Insn_PC         = insn_pc_q;
  assign io_Flush           = flush_q;
  assign io_Redirect_Src    = src_q;

endmodule

// File: doc/fetch_redirect_unit.md
Name: fetch_redirect_unit

Overview:
- Front-end PC generator and fetch sequencer.
- Consumes redirect requests from the decode-stage branch redirect logic (JAL, ID 2) and from the execute stage.
- Issues one instruction-fetch request at a time over a valid/ready memory interface.
- Holds the returned instruction in a one-entry skid register that feeds decode. On a redirect it flushes the skid register and discards any in-flight response.

Parameters:
RESET_PC, 32'h8000_0000, PC loaded on reset
ADDR_W, 32, address/PC width
INSN_W, 32, instruction width

Ports:
clock  in  1  core clock
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
io_needRedirect  in  1  decode-stage redirect request
io_Redirect_ID  in  4  redirect source ID (2 = decode JAL; 0 = none)
io_Redirect_Target  in  32  decode-stage redirect target
io_Exec_Redirect  in  1  execute-stage mispredict redirect
io_Exec_Target  in  32  execute-stage target
io_Fetch_Req_Valid  out  1  fetch request valid
io_Fetch_Req_Addr  out  32  fetch address (word aligned)
io_Fetch_Req_Ready  in  1  memory accepts request
io_Fetch_Resp_Valid  in  1  response valid (single-cycle pulse, in order)
io_Fetch_Resp_Data  in  32  fetched instruction
io_Insn_Valid  out  1  instruction to decode valid
io_Insn  out  32  instruction to decode
io_Insn_PC  out  32  PC of io_Insn
io_Insn_Ready  in  1  decode accepts instruction
io_Flush  out  1  one-cycle pulse, redirect taken (flush downstream)
io_Redirect_Src  out  4  ID of the accepted redirect (15 = execute, else decode ID), valid with io_Flush

Behaviour:
Reset values (async, while reset = 0):
- PC = RESET_PC; state = IDLE.
- All outputs are 0, except io_Fetch_Req_Addr = RESET_PC.

Redirect acceptance:
- A decode redirect is accepted only when io_needRedirect = 1 and io_Redirect_ID != 0.
- An execute redirect has priority over a decode redirect in the same cycle.
- Effect of an accepted redirect, registered in cycle T:
  - In T+1: PC = target with bits [1:0] forced to 0, io_Flush = 1, and io_Redirect_Src holds the winning source.
  - io_Insn_Valid is cleared in T+1.

States:
- IDLE:
  - io_Fetch_Req_Valid = 1, io_Fetch_Req_Addr = PC.
  - On handshake (Valid & Ready): latch req_pc = PC, PC = PC + 4 (wraps modulo 2^32), go to WAIT.
  - Requests are issued only when the skid register is empty, or is being drained in the same cycle (io_Insn_Ready = 1).
- WAIT:
  - io_Fetch_Req_Valid = 0.
  - On io_Fetch_Resp_Valid: load skid register (io_Insn = data, io_Insn_PC = req_pc, io_Insn_Valid = 1), go to IDLE.
  - Redirect without a same-cycle response: go to DRAIN.
  - Redirect with a same-cycle response: discard the response, go to IDLE.
- DRAIN:
  - io_Fetch_Req_Valid = 0.
  - The next io_Fetch_Resp_Valid is discarded and the skid register is untouched; then go to IDLE.
  - A further redirect in DRAIN updates PC and stays in DRAIN.

Redirect while a request is pending in IDLE (Valid & !Ready):
- The request is withdrawn the next cycle and the new PC is presented.
- Valid may drop without Ready; the memory side tolerates this.
- A redirect in the same cycle as a handshake: the handshake counts, and the state goes to DRAIN rather than WAIT.

Skid register:
- Holds io_Insn, io_Insn_PC and io_Insn_Valid stable while io_Insn_Valid & !io_Insn_Ready.
- Cleared on io_Insn_Ready when no new response arrives that cycle.

Other rules:
- Any response arriving in IDLE is ignored.
- io_Flush is never asserted for two consecutive cycles unless two redirects arrive on consecutive cycles.
- Latency: Fetch_Resp_Valid in cycle T gives io_Insn_Valid in T+1.
- Throughput: at most 1 insn per 2 cycles with a 1-cycle memory.

Test Plan:
- Reset release, Req_Ready = 1, 1-cycle responses of 0x13 -> addresses 0x8000_0000, 0x8000_0004, 0x8000_0008 fetched in order; io_Insn_PC matches; io_Flush stays 0.
- Decode redirect (needRedirect = 1, ID = 2, target 0x8000_0100) while in WAIT -> io_Flush = 1 for one cycle with Src = 2; the in-flight response is dropped (io_Insn_Valid remains 0); next request address = 0x8000_0100.
- Exec redirect to 0x8000_0200 and decode redirect to 0x8000_0300 in the same cycle -> PC = 0x8000_0200, Src = 15.
- io_Insn_Ready held 0 for 5 cycles after the first instruction -> io_Insn/io_Insn_PC stable; no new request issued until Ready = 1.
- PC = 0xFFFF_FFFC, fetch accepted -> next fetch address 0x0000_0000; redirect target 0x8000_0103 -> fetch address 0x8000_0100.
- Assert reset (0) in WAIT mid-transaction -> all outputs 0 asynchronously; after release the first request address = RESET_PC, and a late response is ignored in IDLE.
